// File: rtl/bound_flasher_pkg.sv
// Shared types and helpers for the bound-flasher sequencer.
//   state_t  : sequencer FSM states
//   cw()     : lit-count width for n lamps (holds 0..n)
//   pw()     : phase-index width for n phases (at least 1 bit)
//   tbl_get(): field p of a packed per-phase table of w-bit entries
//   tables_ok(): legality of the MAX/MIN phase tables
package bound_flasher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } state_t;

  // Widest packed table: 8 phases x 7-bit counts (64 lamps).
  localparam int unsigned TBL_W = 56;

  function automatic int unsigned cw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned pw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned tbl_get(input logic [TBL_W-1:0] tbl,
                                          input int unsigned      p,
                                          input int unsigned      w);
    logic [TBL_W-1:0] v;
    v = (tbl >> (p * w)) & ((TBL_W'(1) << w) - TBL_W'(1));
    return v[31:0];
  endfunction

  // Each phase must rise above its floor without exceeding the bar, must
  // start its climb from a point below its peak, and the sequence must end dark.
  function automatic bit tables_ok(input logic [TBL_W-1:0] mx,
                                   input logic [TBL_W-1:0] mn,
                                   input int unsigned      np,
                                   input int unsigned      w,
                                   input int unsigned      nl);
    for (int unsigned p = 0; p < np; p++) begin
      if (!(tbl_get(mn, p, w) < tbl_get(mx, p, w))) return 1'b0;
      if (tbl_get(mx, p, w) > nl) return 1'b0;
      if (p > 0 && !(tbl_get(mn, p - 1, w) < tbl_get(mx, p, w))) return 1'b0;
    end
    if (tbl_get(mn, np - 1, w) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/bound_flasher_therm.sv
// Lit count to thermometer decoder (purely combinational).
//   lit   : number of lamps lit, 0..N_LAMPS
//   lamps : lamps[i] = 1 iff i < lit
module bound_flasher_therm
  import bound_flasher_pkg::*;
#(
  parameter int unsigned N_LAMPS = 16
) (
  input  logic [cw(N_LAMPS)-1:0] lit,
  output logic [N_LAMPS-1:0]     lamps
);

  localparam int unsigned CW = cw(N_LAMPS);

  always_comb begin
    lamps = '0;
    for (int unsigned i = 0; i < N_LAMPS; i++) begin
      lamps[i] = (CW'(i) < lit);
    end
  end

endmodule

// File: rtl/bound_flasher_seq.sv
// Bound-flasher sequencer: walks a thermometer lamp bar through a table of
// up/down phases, with flick kick-back at the lit counts set in KICK_MASK.
//   clk, rst : clock, synchronous active-high reset
//   enb      : step strobe, one sequence step per enabled cycle
//   flag     : start request, honoured in IDLE only
//   flick    : kick-back request, honoured on UP steps only
//   lamps    : thermometer of the lit count
//   phase    : current phase index
//   busy     : sequence in progress
//   done     : one-cycle pulse after the final step
module bound_flasher_seq
  import bound_flasher_pkg::*;
#(
  parameter int unsigned                           N_LAMPS   = 16,
  parameter int unsigned                           N_PHASES  = 3,
  parameter logic [N_PHASES*cw(N_LAMPS)-1:0]       PHASE_MAX = {5'd16, 5'd11, 5'd6},
  parameter logic [N_PHASES*cw(N_LAMPS)-1:0]       PHASE_MIN = {5'd0, 5'd5, 5'd0},
  parameter logic [N_LAMPS:0]                      KICK_MASK = (N_LAMPS + 1)'(17'h0840)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic                       flag,
  input  logic                       flick,
  output logic [N_LAMPS-1:0]         lamps,
  output logic [pw(N_PHASES)-1:0]    phase,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CW = cw(N_LAMPS);
  localparam int unsigned PW = pw(N_PHASES);

  if (N_LAMPS < 4 || N_LAMPS > 64) begin : g_bad_lamps
    $fatal(1, "bound_flasher_seq: N_LAMPS out of range 4..64");
  end
  if (N_PHASES < 1 || N_PHASES > 8) begin : g_bad_phases
    $fatal(1, "bound_flasher_seq: N_PHASES out of range 1..8");
  end
  if (!tables_ok(TBL_W'(PHASE_MAX), TBL_W'(PHASE_MIN), N_PHASES, CW, N_LAMPS)) begin : g_bad_tables
    $fatal(1, "bound_flasher_seq: illegal PHASE_MAX/PHASE_MIN table");
  end

  state_t          state_q;
  logic [CW-1:0]   lit_q;
  logic [PW-1:0]   phase_q;
  logic            rpt_q;
  logic            done_q;

  logic [CW-1:0]   max_p;
  logic [CW-1:0]   min_p;
  logic [CW-1:0]   lit_inc;
  logic [CW-1:0]   lit_dec;
  logic            kick;
  logic            turn;
  logic            end_desc;
  logic            rpt_next;
  logic            last_phase;

  always_comb begin
    max_p      = PHASE_MAX[int'(phase_q)*CW +: CW];
    min_p      = PHASE_MIN[int'(phase_q)*CW +: CW];
    lit_inc    = lit_q + CW'(1);
    lit_dec    = lit_q - CW'(1);
    kick       = flick & KICK_MASK[lit_q] & (lit_q > min_p);
    turn       = (state_q == UP) & ((lit_q == max_p) | kick);
    // A turnaround that lands straight on the floor also ends the descent.
    end_desc   = ((state_q == DOWN) | turn) & (lit_dec == min_p);
    rpt_next   = rpt_q | ((state_q == UP) & kick);
    last_phase = (phase_q == PW'(N_PHASES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lit_q   <= '0;
      phase_q <= '0;
      rpt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flag) state_q <= UP;
        end
        UP, DOWN: begin
          if (enb) begin
            lit_q <= (state_q == UP && !turn) ? lit_inc : lit_dec;
            if (end_desc) begin
              if (rpt_next) begin
                rpt_q   <= 1'b0;
                state_q <= UP;
              end else if (last_phase) begin
                state_q <= IDLE;
                phase_q <= '0;
                done_q  <= 1'b1;
              end else begin
                phase_q <= phase_q + PW'(1);
                state_q <= UP;
              end
            end else if (turn) begin
              state_q <= DOWN;
              rpt_q   <= rpt_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bound_flasher_therm #(
    .N_LAMPS (N_LAMPS)
  ) u_therm (
    .lit   (lit_q),
    .lamps (lamps)
  );

  assign phase = phase_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_bound_flasher_seq.sv
module tb_bound_flasher_seq;

  logic        clk = 1'b0;
  logic        rst, enb, flag, flick, flag2;
  logic [15:0] lamps;
  logic [1:0]  phase;
  logic        busy, done;
  logic [7:0]  lamps2;
  logic [0:0]  phase2;
  logic        busy2, done2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bound_flasher_seq u_dut (
    .clk   (clk),
    .rst   (rst),
    .enb   (enb),
    .flag  (flag),
    .flick (flick),
    .lamps (lamps),
    .phase (phase),
    .busy  (busy),
    .done  (done)
  );

  bound_flasher_seq #(
    .N_LAMPS   (8),
    .N_PHASES  (1),
    .PHASE_MAX (4'd8),
    .PHASE_MIN (4'd0),
    .KICK_MASK (9'd0)
  ) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .enb   (enb),
    .flag  (flag2),
    .flick (flick),
    .lamps (lamps2),
    .phase (phase2),
    .busy  (busy2),
    .done  (done2)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model of the default configuration: the bar moves by dir
  // (+1 climbing, -1 falling, 0 idle) between each phase's floor and peak.
  int MX[3] = '{6, 11, 16};
  int MN[3] = '{0, 5, 0};
  int m_L = 0, m_p = 0, m_dir = 0;
  bit m_rep = 0, m_done = 0;

  always @(posedge clk) begin
    bit kicked;
    m_done = 0;
    if (rst) begin
      m_L = 0; m_p = 0; m_dir = 0; m_rep = 0;
    end else if (m_dir == 0) begin
      if (flag) m_dir = 1;
    end else if (enb) begin
      kicked = (m_dir == 1) && flick && (m_L == 6 || m_L == 11) && (m_L > MN[m_p]);
      if (kicked) m_rep = 1;
      if (m_dir == 1 && !kicked && m_L != MX[m_p]) begin
        m_L = m_L + 1;
      end else begin
        m_dir = -1;
        m_L = m_L - 1;
        if (m_L == MN[m_p]) begin
          if (m_rep) begin
            m_rep = 0; m_dir = 1;
          end else if (m_p == 2) begin
            m_dir = 0; m_p = 0; m_done = 1;
          end else begin
            m_p = m_p + 1; m_dir = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("lamps", 64'(lamps), (64'd1 << m_L) - 64'd1);
      check("phase", 64'(phase), 64'(m_p));
      check("busy", 64'(busy), 64'(m_dir != 0));
      check("done", 64'(done), 64'(m_done));
    end
  end

  task automatic pulse_flag();
    @(negedge clk); flag = 1'b1;
    @(negedge clk); flag = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string nm);
    int seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check(nm, 64'(seen), 64'd1);
  endtask

  task automatic run_kick(input int kp, input int kl, output int done_at, output int ph2_at);
    int fired = 0;
    done_at = -1; ph2_at = -1;
    enb = 1'b1;
    pulse_flag();
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      flick = 1'b0;
      if (!fired && int'(phase) == kp && $countones(lamps) == kl) begin
        flick = 1'b1; fired = 1;
      end
      if (phase == 2'd2 && ph2_at < 0) ph2_at = i;
      if (done) begin done_at = i; break; end
    end
    flick = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, ph1_at, ph2_at, peak, strobes, found, seen_bad;
    rst = 1'b1; enb = 1'b0; flag = 1'b0; flick = 1'b0; flag2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_lamps", 64'(lamps), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Plain run: 0->6->0, 0->11->5, 5->16->0.
    enb = 1'b1;
    pulse_flag();
    busy_cnt = busy; done_cnt = 0; done_at = -1; ph1_at = -1; ph2_at = -1; peak = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (phase == 2'd1 && ph1_at < 0) ph1_at = i;
      if (phase == 2'd2 && ph2_at < 0) ph2_at = i;
      if ($countones(lamps) > peak) peak = $countones(lamps);
      if (done) begin done_cnt++; if (done_at < 0) done_at = i; end
    end
    check("t1_phase1_step", 64'(ph1_at), 64'd12);
    check("t1_phase2_step", 64'(ph2_at), 64'd29);
    check("t1_done_step", 64'(done_at), 64'd56);
    check("t1_done_count", 64'(done_cnt), 64'd1);
    check("t1_busy_cycles", 64'(busy_cnt), 64'd56);
    check("t1_peak", 64'(peak), 64'd16);

    // flick held: phase 0 keeps repeating.
    pulse_flag();
    flick = 1'b1;
    peak = 0; seen_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (phase != 2'd0 || !busy || done) seen_bad++;
      if ($countones(lamps) > peak) peak = $countones(lamps);
    end
    check("t2_stuck_phase0", 64'(seen_bad), 64'd0);
    check("t2_peak", 64'(peak), 64'd6);
    flick = 1'b0;
    wait_done(200, "t2_done_after_release");

    // Kick at phase-1 peak: phase 1 repeats once.
    run_kick(1, 11, done_at, ph2_at);
    check("t3_phase2_step", 64'(ph2_at), 64'd41);
    check("t3_done_step", 64'(done_at), 64'd68);

    // Kick below the peak in phase 2: falls to 0 and phase 2 repeats.
    run_kick(2, 6, done_at, ph2_at);
    check("t3b_phase2_step", 64'(ph2_at), 64'd29);
    check("t3b_done_step", 64'(done_at), 64'd68);

    // Stepping one cycle in four, with flag pulsed while busy.
    enb = 1'b0;
    pulse_flag();
    strobes = 0; done_at = -1;
    for (int c = 0; c < 400; c++) begin
      enb = (c % 4 == 0);
      if (enb) strobes++;
      flag = (c >= 40 && c < 50);
      @(negedge clk);
      if (done) begin done_at = strobes; break; end
    end
    enb = 1'b1; flag = 1'b0;
    check("t4_done_strobes", 64'(done_at), 64'd56);

    // Reset mid phase 2 at L=12, with flag and flick also high.
    pulse_flag();
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (phase == 2'd2 && $countones(lamps) == 12) begin found = 1; break; end
    end
    check("t5_reached_l12", 64'(found), 64'd1);
    rst = 1'b1; flag = 1'b1; flick = 1'b1;
    @(negedge clk);
    check("t5_rst_lamps", 64'(lamps), 64'd0);
    check("t5_rst_phase", 64'(phase), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0; flick = 1'b0;
    @(negedge clk);
    flag = 1'b0;
    check("t5_restart_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t5_first_step", 64'(lamps), 64'h1);
    check("t5_first_phase", 64'(phase), 64'd0);
    wait_done(100, "t5_done");

    // Single-phase 8-lamp instance: 0->8->0 in 16 steps.
    @(negedge clk); flag2 = 1'b1;
    @(negedge clk); flag2 = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      int l;
      @(negedge clk);
      l = (k <= 8) ? k : ((k <= 16) ? 16 - k : 0);
      check("t6_lamps", 64'(lamps2), (64'd1 << l) - 64'd1);
      check("t6_busy", 64'(busy2), 64'(k < 16));
      check("t6_phase", 64'(phase2), 64'd0);
      if (done2) done_cnt++;
      if (k == 16) check("t6_done_at_16", 64'(done2), 64'd1);
    end
    check("t6_done_count", 64'(done_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
